// File: rtl/axi_xbar_pkg.sv
// Shared definitions for the AXI router: AXI field widths, the AW sequencing
// state type, and small index/one-hot helpers.
package axi_xbar_pkg;

    localparam int AXI_LEN_W   = 8;
    localparam int AXI_BURST_W = 2;
    localparam int AXI_SIZE_W  = 3;

    typedef enum logic [0:0] {
        AW_IDLE  = 1'b0,
        AW_GRANT = 1'b1
    } aw_state_e;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    // Lowest set bit wins if more than one bit is set.
    function automatic int onehot_to_idx(input logic [31:0] onehot);
        int idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (onehot[i]) idx = i;
        end
        return idx;
    endfunction

    function automatic logic [31:0] idx_to_onehot(input int idx);
        return 32'd1 << idx;
    endfunction

endpackage

// File: rtl/axi_grant_order_fifo.sv
// In-order queue of one-hot AW grants; the head selects which master owns
// the W channel. Head reads zero while the queue is empty.
module axi_grant_order_fifo
    import axi_xbar_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4,
    localparam int PTR_W = clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/axi_write_order_ctrl.sv
// Write-path sequencer: round-robin AW grant, in-order record of accepted
// addresses, and W-channel select held until each burst's WLAST beat.
module axi_write_order_ctrl
    import axi_xbar_pkg::*;
#(
    parameter int AXI_MASTER_PORT = 2,
    parameter int MAX_OUTSTANDING = 4,
    localparam int CNT_WIDTH = clog2(MAX_OUTSTANDING) + 1
) (
    input  logic                       ACLK,
    input  logic                       ARESETN,
    input  logic [AXI_MASTER_PORT-1:0] aw_req_i,
    input  logic                       aw_fire_i,
    input  logic                       w_fire_i,
    input  logic                       w_last_i,
    output logic [AXI_MASTER_PORT-1:0] aw_gnt_o,
    output logic [AXI_MASTER_PORT-1:0] w_gnt_o,
    output logic [CNT_WIDTH-1:0]       outstanding_o,
    output logic                       full_o,
    output logic [AXI_LEN_W-1:0]       w_beat_o,
    output logic                       err_o
);

    localparam int IDX_W = clog2(AXI_MASTER_PORT);

    aw_state_e                    state_q, state_d;
    logic [AXI_MASTER_PORT-1:0]   aw_gnt_q, aw_gnt_d;
    logic [IDX_W-1:0]             rr_ptr_q, rr_ptr_d;
    logic [AXI_LEN_W-1:0]         w_beat_q, w_beat_d;
    logic                         err_q, err_d;
    logic [2*AXI_MASTER_PORT-1:0] req_dbl;
    logic [AXI_MASTER_PORT-1:0]   req_rot;
    logic [AXI_MASTER_PORT-1:0]   rr_pick;
    int                           rr_ofs;
    int                           rr_sel;
    int                           gnt_next;
    logic                         fifo_push;
    logic                         fifo_pop;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic [AXI_MASTER_PORT-1:0]   fifo_head;
    logic [CNT_WIDTH-1:0]         fifo_count;

    // Rotate requests so bit 0 is the RR pointer; the first set bit is the winner.
    always_comb begin
        req_dbl = {aw_req_i, aw_req_i};
        req_rot = req_dbl[{1'b0, rr_ptr_q} +: AXI_MASTER_PORT];
        rr_ofs  = 0;
        for (int i = AXI_MASTER_PORT - 1; i >= 0; i--) begin
            if (req_rot[i]) rr_ofs = i;
        end
        rr_sel = int'(rr_ptr_q) + rr_ofs;
        if (rr_sel >= AXI_MASTER_PORT) rr_sel = rr_sel - AXI_MASTER_PORT;
        rr_pick  = AXI_MASTER_PORT'(idx_to_onehot(rr_sel));
        gnt_next = onehot_to_idx(32'(aw_gnt_q)) + 1;
        if (gnt_next >= AXI_MASTER_PORT) gnt_next = 0;
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) state_q <= AW_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            AW_IDLE:  if (|aw_req_i && !fifo_full) state_d = AW_GRANT;
            AW_GRANT: if (aw_fire_i) state_d = AW_IDLE;
            default:  state_d = AW_IDLE;
        endcase
    end

    // Full is only checked on entry to GRANT, so a held grant can always push.
    always_comb begin
        aw_gnt_d  = aw_gnt_q;
        rr_ptr_d  = rr_ptr_q;
        fifo_push = 1'b0;
        case (state_q)
            AW_IDLE: aw_gnt_d = (|aw_req_i && !fifo_full) ? rr_pick : '0;
            AW_GRANT: begin
                if (aw_fire_i) begin
                    fifo_push = 1'b1;
                    rr_ptr_d  = IDX_W'(gnt_next);
                    aw_gnt_d  = '0;
                end
            end
            default: aw_gnt_d = '0;
        endcase
    end

    always_comb begin
        w_beat_d = w_beat_q;
        err_d    = err_q;
        fifo_pop = 1'b0;
        if (w_fire_i) begin
            if (!fifo_empty) begin
                if (w_last_i) begin
                    fifo_pop = 1'b1;
                    w_beat_d = '0;
                end else begin
                    w_beat_d = w_beat_q + AXI_LEN_W'(1);
                end
            end else begin
                err_d = 1'b1;
            end
        end
        if (aw_fire_i && state_q == AW_IDLE) err_d = 1'b1;
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            aw_gnt_q <= '0;
            rr_ptr_q <= '0;
            w_beat_q <= '0;
            err_q    <= 1'b0;
        end else begin
            aw_gnt_q <= aw_gnt_d;
            rr_ptr_q <= rr_ptr_d;
            w_beat_q <= w_beat_d;
            err_q    <= err_d;
        end
    end

    axi_grant_order_fifo #(
        .WIDTH (AXI_MASTER_PORT),
        .DEPTH (MAX_OUTSTANDING)
    ) u_order_fifo (
        .ACLK        (ACLK),
        .ARESETN     (ARESETN),
        .push_i      (fifo_push),
        .push_data_i (aw_gnt_q),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign aw_gnt_o      = aw_gnt_q;
    assign w_gnt_o       = fifo_head;
    assign outstanding_o = fifo_count;
    assign full_o        = fifo_full;
    assign w_beat_o      = w_beat_q;
    assign err_o         = err_q;

endmodule

// File: doc/axi_write_order_ctrl.md
Name: axi_write_order_ctrl

Overview:
- Sequencing controller for the write path of the AXI slave router: grants the shared AW channel round-robin among AXI_MASTER_PORT requesters.
- Records each accepted AW grant in an in-order queue and drives the W-channel mux select from the queue head, holding it until the WLAST beat completes.
- Decouples AW from W: up to MAX_OUTSTANDING addresses may be accepted ahead of their data.

Parameters:
- AXI_MASTER_PORT, 2, number of requesting master ports (>=2)
- MAX_OUTSTANDING, 4, order-queue depth (power of 2, >=2)
- CNT_WIDTH, $clog2(MAX_OUTSTANDING)+1, width of occupancy count (derived, not overridden)

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  reset, synchronous, active-low
- aw_req_i  in  AXI_MASTER_PORT  per-port AWVALID
- aw_fire_i  in  1  master-side AW handshake (M_AXI_AWVALID & M_AXI_AWREADY)
- w_fire_i  in  1  master-side W handshake (M_AXI_WVALID & M_AXI_WREADY)
- w_last_i  in  1  M_AXI_WLAST
- aw_gnt_o  out  AXI_MASTER_PORT  one-hot AW mux select, registered
- w_gnt_o  out  AXI_MASTER_PORT  one-hot W mux select = queue head, 0 when empty
- outstanding_o  out  CNT_WIDTH  queue occupancy
- full_o  out  1  occupancy == MAX_OUTSTANDING
- w_beat_o  out  8  beat index within current W burst
- err_o  out  1  sticky protocol-error flag

Behaviour:
- Reset (ARESETN low at a rising ACLK edge): aw_gnt_o=0, w_gnt_o=0, outstanding_o=0, full_o=0, w_beat_o=0, err_o=0, RR pointer=0, FSM=IDLE, queue empty. Any in-flight grant is dropped.
- AW FSM, states IDLE and GRANT:
  - IDLE: if |aw_req_i and !full_o, pick the first requester at or after the RR pointer (wrapping). Register its one-hot in aw_gnt_o and go to GRANT. Otherwise stay in IDLE with aw_gnt_o=0.
  - GRANT: hold aw_gnt_o stable, even if the granted aw_req_i bit drops. On aw_fire_i: push aw_gnt_o into the queue, set the RR pointer to granted index+1 (mod AXI_MASTER_PORT), clear aw_gnt_o, return to IDLE.
- Latency:
  - aw_req_i seen at edge n -> aw_gnt_o valid after edge n+1.
  - aw_fire_i at n -> next grant no earlier than after n+2 (one mandatory bubble).
- W side:
  - w_gnt_o is driven from the registered queue head; no combinational path from inputs.
  - w_fire_i with w_gnt_o!=0 increments w_beat_o (wraps at 255).
  - w_fire_i & w_last_i pops the head and clears w_beat_o to 0.
  - A push into an empty queue makes w_gnt_o valid after the following edge.
- Simultaneous push and pop: occupancy unchanged. Head advances to the next entry, or to the just-pushed entry if only one entry was present.
- Full: no new AW grant is issued while full. A grant already in GRANT still completes, because full is checked only on entry to GRANT, so a push when full is impossible.
- Errors, all set err_o next edge and held until reset:
  - w_fire_i while w_gnt_o==0: beat ignored, no pop.
  - aw_fire_i while FSM in IDLE: no push.
- Occupancy arithmetic is CNT_WIDTH-bit and never overflows or underflows by construction. Read and write pointers are $clog2(MAX_OUTSTANDING)-bit and wrap naturally.

Decomposition:
- Shared package axi_xbar_pkg holds:
  - the clog2 helper;
  - one-hot-to-index and index-to-one-hot functions;
  - localparams for the AXI burst/len field widths already used by the router.
- Sub-module axi_grant_order_fifo: synchronous FIFO of one-hot grants.
  - Ports: push/pop/head/count/full/empty.
  - Synchronous active-low reset on ARESETN.
- RR selection stays inline in this module.

Test Plan:
- Reset: hold ARESETN=0 for 2 edges with aw_req_i=2'b11 and w_fire_i=1 -> all outputs 0 and err_o=0 throughout.
- Single burst: aw_req_i=01 at edge 0 -> aw_gnt_o=01 after edge 1. Then:
  - aw_fire_i at edge 3 -> aw_gnt_o=00 and w_gnt_o=01 after edge 4, outstanding_o=1.
  - 4 w_fire_i beats (last on 4th) -> w_beat_o 0,1,2,3 then 0; w_gnt_o=00; outstanding_o=0.
- Round robin: aw_req_i=11 held, aw_fire_i pulsed whenever aw_gnt_o!=0 -> grant sequence 01,10,01,10, and w_gnt_o pops in the same order.
- Full: 4 AWs accepted with no W beats -> outstanding_o=4, full_o=1, aw_gnt_o stays 0 with aw_req_i=10 pending. WLAST pop at edge n -> full_o=0 after n+1, aw_gnt_o=10 after n+2.
- Simultaneous: outstanding_o=1 (head 01), aw_fire_i for grant 10 and w_fire_i&w_last_i on the same edge -> outstanding_o stays 1, w_gnt_o=10 next.
- Error: w_fire_i=1 with the queue empty -> err_o=1 after next edge, outstanding_o stays 0, err_o stays 1 until ARESETN=0.
